// File: rtl/serial_addsub_seq.sv
// Bit-serial adder/subtractor: one full adder is reused once per clock, LSB first,
// behind a valid/ready request port and a valid/ready result port.

module add1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_next;
    logic             bit_sum;
    logic             bit_cout;
    logic             c_msb_in;

    // Subtraction is A + ~B + 1: B is inverted at accept and the +1 enters
    // through the carry register, so the adder never knows which op it runs.
    add1 u_add1 (
        .a    (a_reg[cnt]),
        .b    (b_reg[cnt]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_cout)
    );

    // On the final BUSY edge the carry register still holds the carry into the MSB.
    assign c_msb_in = carry;

    // NOTE: every variable written in always_comb gets a full default first,
    // otherwise the partial bit update below would infer a latch.
    always_comb begin
        result_next      = result;
        result_next[cnt] = bit_sum;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= sub;
                        cnt      <= '0;
                        result   <= '0;
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    result <= result_next;
                    carry  <= bit_cout;
                    if (cnt == LAST_BIT) begin
                        // Counter returns to 0 instead of wrapping past WIDTH-1.
                        cnt       <= '0;
                        overflow  <= c_msb_in ^ bit_cout;
                        zero      <= (result_next == '0);
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_addsub_seq.md
SERIAL_ADDSUB_SEQ -- requirements
Module: serial_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-012 carry  output  1  final carry out of MSB (for sub: 1 = no borrow).
REQ-013 overflow  output  1  signed overflow.
REQ-014 zero  output  1  result == 0.
REQ-015 busy  output  1  high in BUSY state.

Function
REQ-016 The block SHALL compute with exactly one instance of the team 1-bit full adder (add1), one bit per clock, LSB first.
REQ-017 FSM states SHALL be IDLE, BUSY and DONE; encoding is free.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in BUSY.
REQ-019 Accept = in_valid & in_ready at a rising edge; on accept: latch A, latch (sub ? ~B : B), set carry register = sub, clear bit counter, clear result register, go to BUSY.
REQ-020 in_valid without in_ready SHALL be ignored; inputs a, b, sub SHALL be ignored outside the accept edge.
REQ-021 Each BUSY edge: add1 inputs = A[cnt], B'[cnt], carry register; sum written to result[cnt]; carry register <= carry_out; cnt increments.
REQ-022 On the BUSY edge processing bit WIDTH-1: capture carry-in of that bit as c_msb_in, go to DONE; BUSY lasts exactly WIDTH cycles.
REQ-023 Latency: out_valid SHALL rise WIDTH edges after the accept edge.
REQ-024 overflow SHALL equal c_msb_in XOR final carry; zero SHALL equal (result == 0); carry SHALL equal the final carry register.
REQ-025 In DONE, result and all flags SHALL hold stable until out_valid & out_ready at a rising edge, then go to IDLE.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 No back-to-back overlap: a new request is accepted no earlier than the edge after the completing DONE handshake.
REQ-028 Counter SHALL be ceil(log2(WIDTH)) bits minimum and never wrap in operation; no counter state outside 0..WIDTH-1 is reachable.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, result=0, carry=0, overflow=0, zero=0, counter=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; no out_valid SHALL follow for it.
REQ-031 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=4)
REQ-032 a=3,b=5,sub=0 -> after 4 BUSY cycles result=1000, carry=0, overflow=1, zero=0.
REQ-033 a=7,b=7,sub=1 -> result=0000, carry=1, overflow=0, zero=1; a=0,b=1,sub=1 -> result=1111, carry=0, overflow=0.
REQ-034 a=15,b=1,sub=0 -> result=0000, carry=1, overflow=0, zero=1; a=8,b=1,sub=1 -> result=0111, carry=1, overflow=1.
REQ-035 out_ready held low 3 cycles in DONE -> result/flags/out_valid constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 rst_n pulsed low at BUSY cycle 2 -> outputs at reset values asynchronously, no out_valid; next request 2+3 -> result=0101.
REQ-037 Random 1000 requests with random in_valid/out_ready gaps vs. reference model -> all results/flags match, in-order, none lost or duplicated.
